// File: rtl/axi_txn_sequencer.sv
`default_nettype none
// axi_txn_sequencer -- queued command issue with repeat, inter-transaction gap,
// completion timeout and sticky error status.  Rev 1.0
module axi_txn_sequencer #(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_type,
  input  logic [7:0]                        cmd_repeat,
  input  logic                              clr_err,
  output logic                              txn_start,
  output logic [1:0]                        txn_type,
  input  logic                              txn_done,
  output logic                              busy,
  output logic [15:0]                       done_cnt,
  output logic                              err_timeout,
  output logic                              err_spurious,
  output logic [$clog2(CMD_FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(CMD_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(CMD_FIFO_DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      mem_q [CMD_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      type_q, type_d;
  logic [7:0]      rep_q, rep_d;
  logic [15:0]     tmr_q, tmr_d;
  logic [7:0]      gap_q, gap_d;
  logic [15:0]     done_cnt_q, done_cnt_d;
  logic            err_to_q, err_to_d;
  logic            err_sp_q, err_sp_d;
  logic            start_q, start_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            push;
  logic            pop;
  logic [9:0]      head;

  assign push = cmd_valid && ready_q;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    rep_d      = rep_q;
    tmr_d      = tmr_q;
    gap_d      = gap_q;
    done_cnt_d = done_cnt_q;
    err_to_d   = err_to_q;
    err_sp_d   = err_sp_q;
    pop        = 1'b0;

    if (clr_err) begin
      err_to_d = 1'b0;
      err_sp_d = 1'b0;
    end
    if (txn_done && (state_q != S_WAIT)) begin
      err_sp_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          type_d  = head[9:8];
          rep_d   = head[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done landing on the expiry cycle takes priority over the timeout.
        if (txn_done) begin
          done_cnt_d = done_cnt_q + 16'd1;
          gap_d      = '0;
          if (GAP_CYCLES == 0) begin
            if (rep_q != 8'd0) begin
              rep_d   = rep_q - 8'd1;
              state_d = S_ISSUE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_GAP;
          end
        end else if (tmr_q == TMO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_ERROR;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (rep_q != 8'd0) begin
            rep_d   = rep_q - 8'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_ERROR: begin
        if (clr_err) begin
          rep_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    start_d = (state_d == S_ISSUE);
    ready_d = (level_d != FULL_LVL);
    busy_d  = (state_d != S_IDLE) || (level_d != '0);
  end

  // Storage needs no reset: clearing the pointers and level discards its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_type, cmd_repeat};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      type_q     <= 2'b00;
      rep_q      <= '0;
      tmr_q      <= '0;
      gap_q      <= '0;
      done_cnt_q <= '0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
      start_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      type_q     <= type_d;
      rep_q      <= rep_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
      done_cnt_q <= done_cnt_d;
      err_to_q   <= err_to_d;
      err_sp_q   <= err_sp_d;
      start_q    <= start_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign txn_start    = start_q;
  assign txn_type     = type_q;
  assign busy         = busy_q;
  assign done_cnt     = done_cnt_q;
  assign err_timeout  = err_to_q;
  assign err_spurious = err_sp_q;
  assign fifo_level   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_txn_sequencer.sv
`default_nettype none
// tb_axi_txn_sequencer -- directed vectors for the command sequencer
// (depth 4, gap 2, timeout 8) with a delayed-done responder.
module tb_axi_txn_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [7:0]  cmd_repeat;
  logic        clr_err;
  logic        txn_start;
  logic [1:0]  txn_type;
  logic        txn_done;
  logic        busy;
  logic [15:0] done_cnt;
  logic        err_timeout;
  logic        err_spurious;
  logic [2:0]  fifo_level;

  logic        man_done;
  logic        resp_done;
  logic        resp_en;
  int          resp_d;
  int          rd_cnt;

  int          cyc;
  int          st_n, dn_n, b2b;
  int          st_cyc [64];
  logic [1:0]  st_ty [64];
  int          dn_cyc [64];
  logic        prev_start;

  int          n_vec, n_err;

  assign txn_done = resp_done | man_done;

  axi_txn_sequencer #(
    .CMD_FIFO_DEPTH (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_repeat   (cmd_repeat),
    .clr_err      (clr_err),
    .txn_start    (txn_start),
    .txn_type     (txn_type),
    .txn_done     (txn_done),
    .busy         (busy),
    .done_cnt     (done_cnt),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc  = 0;
    dn_n = 0;
  end

  always @(posedge clk) begin
    if (txn_done) begin
      if (dn_n < 64) dn_cyc[dn_n] = cyc;
      dn_n++;
    end
    cyc++;
  end

  // Start monitor plus responder: done is returned resp_d cycles after a start.
  initial begin
    st_n = 0; b2b = 0; prev_start = 1'b0; rd_cnt = 0; resp_done = 1'b0;
  end

  always @(negedge clk) begin
    if (txn_start) begin
      if (st_n < 64) begin
        st_cyc[st_n] = cyc;
        st_ty[st_n]  = txn_type;
      end
      st_n++;
    end
    if (txn_start && prev_start) b2b++;
    prev_start = txn_start;
    if (rd_cnt != 0) begin
      rd_cnt--;
      resp_done = (rd_cnt == 0);
    end else begin
      resp_done = 1'b0;
    end
    if (resp_en && txn_start) rd_cnt = resp_d;
  end

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [1:0] t, input logic [7:0] r);
    cmd_valid  = 1'b1;
    cmd_type   = t;
    cmd_repeat = r;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk_vec({tag, "_ready"},  32'(cmd_ready),    32'd1);
    chk_vec({tag, "_start"},  32'(txn_start),    32'd0);
    chk_vec({tag, "_type"},   32'(txn_type),     32'd0);
    chk_vec({tag, "_busy"},   32'(busy),         32'd0);
    chk_vec({tag, "_dcnt"},   32'(done_cnt),     32'd0);
    chk_vec({tag, "_eto"},    32'(err_timeout),  32'd0);
    chk_vec({tag, "_esp"},    32'(err_spurious), 32'd0);
    chk_vec({tag, "_level"},  32'(fifo_level),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c0, base, dbase, budget;
    logic [1:0] exp_ty [6];
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_repeat = 8'd0;
    clr_err = 1'b0; man_done = 1'b0; resp_en = 1'b0; resp_d = 5;
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single command, repeat 0, done 5 cycles after start.
    resp_en = 1'b1; resp_d = 5;
    base = st_n; t0 = cyc;
    push(2'b01, 8'd0);
    chk_vec("t1_level", 32'(fifo_level), 32'd1);
    wait_to(t0 + 10);
    chk_vec("t1_busy_gap", 32'(busy), 32'd1);
    tick();
    chk_vec("t1_busy_idle", 32'(busy), 32'd0);
    wait_to(t0 + 14);
    chk_vec("t1_nstart", 32'(st_n - base), 32'd1);
    chk_vec("t1_lat", 32'(st_cyc[base] - t0), 32'd2);
    chk_vec("t1_type", 32'(st_ty[base]), 32'd1);
    chk_vec("t1_dcnt", 32'(done_cnt), 32'd1);

    // Repeat 3: four starts, each 4 cycles after the previous done.
    base = st_n; dbase = dn_n; t0 = cyc;
    push(2'b10, 8'd3);
    wait_to(t0 + 40);
    chk_vec("t2_nstart", 32'(st_n - base), 32'd4);
    chk_vec("t2_lat", 32'(st_cyc[base] - t0), 32'd2);
    for (int i = 0; i < 3; i++)
      chk_vec("t2_gap", 32'(st_cyc[base+i+1] - dn_cyc[dbase+i]), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_vec("t2_type", 32'(st_ty[base+i]), 32'd2);
    chk_vec("t2_dcnt", 32'(done_cnt), 32'd5);
    chk_vec("t2_busy", 32'(busy), 32'd0);

    // Fill the FIFO behind a slow transaction; the sixth push waits for a pop.
    resp_d = 7;
    exp_ty[0] = 2'd1; exp_ty[1] = 2'd2; exp_ty[2] = 2'd3;
    exp_ty[3] = 2'd0; exp_ty[4] = 2'd1; exp_ty[5] = 2'd2;
    base = st_n; t0 = cyc;
    push(exp_ty[0], 8'd0);
    wait_to(t0 + 3);
    for (int i = 1; i < 5; i++) push(exp_ty[i], 8'd0);
    chk_vec("t3_full_ready", 32'(cmd_ready), 32'd0);
    chk_vec("t3_full_level", 32'(fifo_level), 32'd4);
    cmd_valid = 1'b1; cmd_type = exp_ty[5]; cmd_repeat = 8'd0;
    tick();
    chk_vec("t3_ignored_level", 32'(fifo_level), 32'd4);
    budget = 30;
    while (!cmd_ready && budget > 0) begin
      tick();
      budget--;
    end
    chk_vec("t3_ready_cyc", 32'(cyc - t0), 32'd14);
    tick();
    cmd_valid = 1'b0;
    wait_to(t0 + 77);
    chk_vec("t3_nstart", 32'(st_n - base), 32'd6);
    for (int i = 0; i < 6; i++)
      chk_vec("t3_order", 32'(st_ty[base+i]), 32'(exp_ty[i]));
    chk_vec("t3_dcnt", 32'(done_cnt), 32'd11);

    // Timeout with no done; clr_err drops leftover repeats and runs the next command.
    resp_en = 1'b0;
    base = st_n; t0 = cyc;
    push(2'b11, 8'd2);
    push(2'b01, 8'd0);
    wait_to(t0 + 10);
    chk_vec("t4_eto_before", 32'(err_timeout), 32'd0);
    tick();
    chk_vec("t4_eto_rise", 32'(err_timeout), 32'd1);
    wait_to(t0 + 16);
    chk_vec("t4_hold_nstart", 32'(st_n - base), 32'd1);
    chk_vec("t4_hold_busy", 32'(busy), 32'd1);
    chk_vec("t4_hold_level", 32'(fifo_level), 32'd1);
    resp_en = 1'b1; resp_d = 3;
    clr_err = 1'b1; c0 = cyc;
    tick();
    clr_err = 1'b0;
    chk_vec("t4_eto_clr", 32'(err_timeout), 32'd0);
    wait_to(c0 + 15);
    chk_vec("t4_nstart", 32'(st_n - base), 32'd2);
    chk_vec("t4_next_lat", 32'(st_cyc[base+1] - c0), 32'd2);
    chk_vec("t4_next_type", 32'(st_ty[base+1]), 32'd1);
    chk_vec("t4_dcnt", 32'(done_cnt), 32'd12);
    chk_vec("t4_busy", 32'(busy), 32'd0);

    // Spurious done while IDLE, then done coincident with timeout expiry.
    chk_vec("t5_esp_before", 32'(err_spurious), 32'd0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk_vec("t5_esp_set", 32'(err_spurious), 32'd1);
    chk_vec("t5_dcnt_same", 32'(done_cnt), 32'd12);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_vec("t5_esp_clr", 32'(err_spurious), 32'd0);
    resp_d = 8;
    t0 = cyc;
    push(2'b10, 8'd0);
    wait_to(t0 + 12);
    chk_vec("t5_coinc_eto", 32'(err_timeout), 32'd0);
    chk_vec("t5_coinc_dcnt", 32'(done_cnt), 32'd13);
    wait_to(t0 + 16);
    chk_vec("t5_coinc_busy", 32'(busy), 32'd0);
    chk_vec("t5_coinc_esp", 32'(err_spurious), 32'd0);

    // Reset in WAIT with two queued commands.
    resp_en = 1'b0;
    base = st_n; t0 = cyc;
    push(2'b00, 8'd0);
    wait_to(t0 + 3);
    push(2'b01, 8'd0);
    push(2'b10, 8'd0);
    chk_vec("t6_level", 32'(fifo_level), 32'd2);
    wait_to(t0 + 6);
    rst_n = 1'b0;
    tick();
    chk_reset("t6");
    rst_n = 1'b1;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk_vec("t6_late_esp", 32'(err_spurious), 32'd1);
    repeat (15) tick();
    chk_vec("t6_nstart", 32'(st_n - base), 32'd1);
    chk_vec("t6_dcnt", 32'(done_cnt), 32'd0);

    chk_vec("no_b2b_start", 32'(b2b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_txn_sequencer.md
# axi_txn_sequencer

Command sequencer sitting directly upstream of the AXI master/slave pair top, driving its `txn_start`/`txn_type` inputs and consuming its `txn_done` output. It buffers transaction commands in a small FIFO, issues each as a one-cycle start pulse, repeats it a programmable number of times, and enforces inter-transaction gaps and a completion timeout. It also maintains completion and error status for the testbench or a host register block.

## Interface
- `CMD_FIFO_DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `GAP_CYCLES`, 2: idle cycles inserted after each `txn_done`, 0..255; 0 skips the gap.
- `TIMEOUT_CYCLES`, 1024: maximum WAIT cycles before a timeout error, 1..65535.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `cmd_valid`  in  1  command push request.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_type`  in  2  `txn_type` value to issue; opaque to this block.
- `cmd_repeat`  in  8  extra issues; the command is issued `cmd_repeat`+1 times.
- `clr_err`  in  1  pulse that leaves the ERROR state and clears sticky errors.
- `txn_start`  out  1  one-cycle start pulse to the downstream block.
- `txn_type`  out  2  type of the current transaction.
- `txn_done`  in  1  one-cycle completion pulse from the downstream block.
- `busy`  out  1  state is not IDLE, or the FIFO is not empty.
- `done_cnt`  out  16  count of accepted completions.
- `err_timeout`  out  1  sticky timeout flag.
- `err_spurious`  out  1  sticky flag for `txn_done` received outside WAIT.
- `fifo_level`  out  $clog2(CMD_FIFO_DEPTH)+1  number of FIFO entries.

## Operation
- FIFO:
  - Push occurs when `cmd_valid && cmd_ready`.
  - `cmd_ready` is `!full`, derived from registered state only.
  - Push and pop in the same cycle are allowed. The level is unchanged, and the pointers wrap modulo depth.
  - A push while full is ignored because `cmd_ready` is 0.
- FSM states: IDLE, ISSUE, WAIT, GAP, ERROR.
  - IDLE:
    - If the FIFO is non-empty: pop the head, load `txn_type` and `rep_left = cmd_repeat`, then go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: `txn_start` = 1 for exactly this cycle. Clear the timeout counter and go to WAIT.
  - WAIT:
    - Count cycles.
    - On `txn_done`: increment `done_cnt` (wraps 0xFFFF→0x0000). Go to GAP, or skip GAP when `GAP_CYCLES` = 0.
    - If the counter reaches `TIMEOUT_CYCLES` without `txn_done`: set `err_timeout` and go to ERROR.
    - If `txn_done` arrives in the same cycle the counter expires, the done wins: count it, no error.
  - GAP: count `GAP_CYCLES` cycles, then:
    - if `rep_left` > 0: decrement `rep_left` and go to ISSUE, with `txn_type` unchanged;
    - otherwise go to IDLE.
  - ERROR:
    - Holds and issues nothing.
    - Pushes are still accepted.
    - `clr_err` clears `err_timeout` and `err_spurious`, discards the remaining repeats, and returns to IDLE.
- `txn_done` outside WAIT is ignored for counting, sets `err_spurious`, and has no FSM effect.
- `clr_err` outside ERROR clears both sticky flags only.
- `txn_type` is registered and is stable from ISSUE until the next load.

## Timing
- Reset values:
  - State is IDLE and the FIFO is empty.
  - `cmd_ready` = 1, `txn_start` = 0, `txn_type` = 2'b00, `busy` = 0, `done_cnt` = 0, both errors = 0, `fifo_level` = 0.
- Reset mid-transaction aborts immediately. Queued commands are lost and late `txn_done` pulses after reset count as spurious.
- All outputs are registered.
- Latency:
  - A push handshake in cycle N on an empty FIFO in IDLE gives `txn_start` high in cycle N+2.
  - `fifo_level` updates in cycle N+1.
- Back-to-back repeats: `txn_done` in cycle M gives the next `txn_start` in cycle M+`GAP_CYCLES`+2.
  - GAP is entered at M+1.
  - For `GAP_CYCLES` = 0, the next ISSUE is at M+1.
- Next command: after the last repeat's gap, the FSM is in IDLE for one cycle, then ISSUE.
- Timeout: with `txn_start` in cycle S and no done, `err_timeout` rises in cycle S+`TIMEOUT_CYCLES`+1.
- `txn_start` never asserts on two consecutive cycles.

## Test plan
- Single command, type 2'b01, repeat 0, bench returns `txn_done` 5 cycles after start -> exactly one `txn_start` at N+2 with `txn_type` = 01; `done_cnt` = 1; `busy` falls after the gap plus 1 cycle.
- Repeat 3 with `GAP_CYCLES` = 2 -> 4 start pulses, each 4 cycles after the preceding done; `done_cnt` = 4.
- Push 5 commands with depth 4 while the bench stalls done -> `cmd_ready` = 0 at level 4; the fifth is accepted after the first pop; all 5 types are issued in order.
- No `txn_done`, `TIMEOUT_CYCLES` = 8 -> `err_timeout` rises at S+9 and the FSM holds in ERROR; `clr_err` -> IDLE, the next queued command issues, `err_timeout` = 0.
- `txn_done` pulsed while IDLE, and `txn_done` coincident with the timeout expiry cycle -> `err_spurious` = 1 in the first case; the second is counted as done with `err_timeout` = 0.
- Reset asserted during WAIT with 2 queued commands -> the next cycle shows all reset values; no `txn_start` follows.
